// File: rtl/delta_ctrl_pkg.sv
// Shared system constants and the output-storer state type.
// The system geometry (PU count, channel widths, tile step, feature limits) lives here.
// Storer-local widths are derived from that geometry.
package delta_ctrl_pkg;

    localparam int PU_NUM             = 4;
    localparam int OUTPUT_CHANNEL     = 4;
    localparam int BIN_LEN            = 8;
    localparam int OUT_BIN_LEN        = 16;
    localparam int OUTPUT_WIDTH       = 4;
    localparam int MAX_OUTPUT_CHANNEL = 64;
    localparam int MAX_FEATURE_SIZE   = 64;

    localparam int OC_W      = $clog2(MAX_OUTPUT_CHANNEL);
    localparam int ORC_W     = $clog2(MAX_FEATURE_SIZE);
    localparam int PU_IDX_W  = $clog2(PU_NUM + 1);
    localparam int PU_SEL_W  = (PU_NUM > 1) ? $clog2(PU_NUM) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PU_CHECK,
        RD_OB,
        PACK,
        WR,
        PU_PLUS,
        OUTPUT_PLUS
    } out_state_t;

endpackage

// File: rtl/delta_out_quantizer.sv
// Per-lane narrowing of a signed accumulator value to a signed BIN_LEN code.
// Latency: purely combinational.
// Backpressure: none; DELTA_OUT_RELU_EN clamps negatives to zero before saturation.
module delta_out_quantizer
    import delta_ctrl_pkg::*;
(
    input  logic [OUT_BIN_LEN-1:0] din,
    output logic [BIN_LEN-1:0]     dout
);

    localparam logic signed [OUT_BIN_LEN-1:0] Q_MAX = OUT_BIN_LEN'((1 << (BIN_LEN - 1)) - 1);
    localparam logic signed [OUT_BIN_LEN-1:0] Q_MIN = OUT_BIN_LEN'(-(1 << (BIN_LEN - 1)));

    logic signed [OUT_BIN_LEN-1:0] v;

    always_comb begin
        v = $signed(din);
`ifdef DELTA_OUT_RELU_EN
        if (v[OUT_BIN_LEN-1]) begin
            v = '0;
        end
`endif
        if (v > Q_MAX) begin
            dout = Q_MAX[BIN_LEN-1:0];
        end else if (v < Q_MIN) begin
            dout = Q_MIN[BIN_LEN-1:0];
        end else begin
            dout = v[BIN_LEN-1:0];
        end
    end

endmodule

// File: rtl/delta_controller_output_storer.sv
// Drains one output tile from the PU output buffers to DRAM, one packed 32-bit word per PU.
// Latency: PU_NUM*5+3 cycles start-to-finished when each write is accepted after one cycle.
// Backpressure: WR holds request, address and data until DRAM_WriteDone; optional DELTA_OUT_RELU_EN.
module delta_controller_output_storer
    import delta_ctrl_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic                                                  start,
    input  logic [OC_W-1:0]                                       OC_Num,
    input  logic [ORC_W-1:0]                                      ORC_Size,
    input  logic [31:0]                                           output_start_address,
    input  logic [PU_NUM-1:0][OUTPUT_CHANNEL-1:0][OUT_BIN_LEN-1:0] OB_rdata,
    output logic [PU_NUM-1:0][OUTPUT_CHANNEL-1:0]                 OB_r_enable,
    output logic                                                  DRAM_Write,
    output logic [31:0]                                           DRAM_Address,
    output logic [31:0]                                           DRAM_WriteData,
    input  logic                                                  DRAM_WriteDone,
    output logic                                                  finished
);

    localparam logic [PU_IDX_W-1:0] PU_DONE  = PU_IDX_W'(PU_NUM);
    localparam logic [ORC_W-1:0]    TILE_STEP = ORC_W'(OUTPUT_WIDTH);

    out_state_t               state;
    out_state_t               state_nxt;
    logic [PU_IDX_W-1:0]      pu_idx;
    logic [PU_SEL_W-1:0]      pu_sel;
    logic [ORC_W-1:0]         output_r;
    logic [ORC_W-1:0]         output_c;
    logic [OC_W-1:0]          oc_num_q;
    logic [31:0]              data_q;
    logic [31:0]              packed_word;
    logic [LANES-1:0][BIN_LEN-1:0] q_lane;
    logic                     unused_oc;

    assign pu_sel         = pu_idx[PU_SEL_W-1:0];
    assign DRAM_WriteData = data_q;
    // Channel count is held for the surrounding controller; nothing here consumes it.
    assign unused_oc      = ^oc_num_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        delta_out_quantizer u_quant (
            .din  (OB_rdata[pu_sel][g]),
            .dout (q_lane[g])
        );
    end

    always_comb begin
        packed_word = '0;
        for (int i = 0; i < LANES; i++) begin
            packed_word[i*BIN_LEN +: BIN_LEN] = q_lane[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        OB_r_enable = '0;
        DRAM_Write  = 1'b0;
        finished    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PU_CHECK;
                end
            end
            PU_CHECK: begin
                state_nxt = (pu_idx == PU_DONE) ? OUTPUT_PLUS : RD_OB;
            end
            RD_OB: begin
                OB_r_enable[pu_sel] = '1;
                state_nxt           = PACK;
            end
            PACK: begin
                state_nxt = WR;
            end
            WR: begin
                DRAM_Write = 1'b1;
                if (DRAM_WriteDone) begin
                    state_nxt = PU_PLUS;
                end
            end
            PU_PLUS: begin
                state_nxt = PU_CHECK;
            end
            OUTPUT_PLUS: begin
                finished  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pu_idx       <= '0;
            output_r     <= '0;
            output_c     <= '0;
            oc_num_q     <= '0;
            data_q       <= '0;
            DRAM_Address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        oc_num_q <= OC_Num;
                        // Only the first tile of a frame rebases; later tiles append.
                        if (output_r == '0 && output_c == '0) begin
                            DRAM_Address <= output_start_address;
                        end
                    end
                end
                PACK: begin
                    data_q <= packed_word;
                end
                PU_PLUS: begin
                    DRAM_Address <= DRAM_Address + 32'(ADDR_STRIDE);
                    pu_idx       <= pu_idx + 1'b1;
                end
                OUTPUT_PLUS: begin
                    pu_idx <= '0;
                    if (output_c >= ORC_Size) begin
                        output_c <= '0;
                        if (output_r >= ORC_Size) begin
                            output_r <= '0;
                        end else begin
                            output_r <= output_r + TILE_STEP;
                        end
                    end else begin
                        output_c <= output_c + TILE_STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delta_controller_output_storer.sv
// Randomized scoreboard bench for delta_controller_output_storer with a tile-level reference model.
module tb_delta_controller_output_storer;
    import delta_ctrl_pkg::*;

    localparam int LANES  = 4;
    localparam int STRIDE = 4;

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic [OC_W-1:0]  OC_Num;
    logic [ORC_W-1:0] ORC_Size;
    logic [31:0]      output_start_address;
    logic [PU_NUM-1:0][OUTPUT_CHANNEL-1:0][OUT_BIN_LEN-1:0] OB_rdata;
    logic [PU_NUM-1:0][OUTPUT_CHANNEL-1:0] OB_r_enable;
    logic        DRAM_Write;
    logic [31:0] DRAM_Address;
    logic [31:0] DRAM_WriteData;
    logic        DRAM_WriteDone;
    logic        finished;

    delta_controller_output_storer #(.LANES(LANES), .ADDR_STRIDE(STRIDE)) dut (
        .clock                (clock),
        .reset                (reset),
        .start                (start),
        .OC_Num               (OC_Num),
        .ORC_Size             (ORC_Size),
        .output_start_address (output_start_address),
        .OB_rdata             (OB_rdata),
        .OB_r_enable          (OB_r_enable),
        .DRAM_Write           (DRAM_Write),
        .DRAM_Address         (DRAM_Address),
        .DRAM_WriteData       (DRAM_WriteData),
        .DRAM_WriteDone       (DRAM_WriteDone),
        .finished             (finished)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_fin = 0;
    int          m_r = 0;
    int          m_c = 0;
    logic [31:0] m_addr = '0;
    logic signed [OUT_BIN_LEN-1:0] ob_mem[PU_NUM][OUTPUT_CHANNEL];

    function automatic logic [31:0] pack_word(input int p);
        logic [31:0] w  = '0;
        int          hi = (1 << (BIN_LEN - 1)) - 1;
        int          lo = -(1 << (BIN_LEN - 1));
        int          v;
        for (int i = 0; i < LANES; i++) begin
            v = ob_mem[p][i];
`ifdef DELTA_OUT_RELU_EN
            if (v < 0) v = 0;
`endif
            if (v > hi) v = hi;
            if (v < lo) v = lo;
            w = w | ((32'(v) & ((32'd1 << BIN_LEN) - 1)) << (i * BIN_LEN));
        end
        return w;
    endfunction

    task automatic model_start(input int orc, input logic [31:0] addr);
        wr_t e;
        if (m_r == 0 && m_c == 0) m_addr = addr;
        for (int p = 0; p < PU_NUM; p++) begin
            e.addr = m_addr;
            e.data = pack_word(p);
            exp_wr.push_back(e);
            m_addr = m_addr + STRIDE;
        end
        exp_fin++;
        if (m_c >= orc) begin
            m_c = 0;
            m_r = (m_r >= orc) ? 0 : (m_r + OUTPUT_WIDTH) % MAX_FEATURE_SIZE;
        end else begin
            m_c = (m_c + OUTPUT_WIDTH) % MAX_FEATURE_SIZE;
        end
    endtask

    task automatic model_reset();
        m_r = 0;
        m_c = 0;
        m_addr = '0;
        exp_wr.delete();
        exp_fin = 0;
    endtask

    // ---------------- DRAM responder and output-buffer emulation ----------------
    int d_min = 1;
    int d_max = 1;
    bit spur_en = 1'b0;
    int wcnt = 0;
    int cur_d = 1;
    logic [PU_NUM-1:0][OUTPUT_CHANNEL-1:0] en_seen = '0;

    always @(posedge clock) begin
        #1;
        if (DRAM_Write) begin
            if (wcnt == 0) cur_d = $urandom_range(d_max, d_min);
            wcnt++;
            DRAM_WriteDone = (wcnt == cur_d);
        end else begin
            wcnt = 0;
            DRAM_WriteDone = spur_en && ($urandom_range(0, 3) == 0);
        end
    end

    // Read data is only meaningful the cycle after its enable; anything else is noise.
    always @(posedge clock) begin
        #1;
        for (int p = 0; p < PU_NUM; p++) begin
            for (int c = 0; c < OUTPUT_CHANNEL; c++) begin
                OB_rdata[p][c] = en_seen[p][c] ? ob_mem[p][c] : OUT_BIN_LEN'($urandom);
            end
        end
    end

    // ---------------- monitor ----------------
    logic        prev_write = 1'b0;
    logic        prev_fin   = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_data  = '0;
    int          fin_seen   = 0;
    int          fin_cyc    = 0;
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];

    always @(negedge clock) begin
        wr_t e;
        int  rows;
        bit  ok;
        if (!reset) begin
            if (DRAM_Write && !prev_write) begin
                wr_addr_log.push_back(DRAM_Address);
                wr_data_log.push_back(DRAM_WriteData);
                if (exp_wr.size() == 0) begin
                    fail_event("unexpected_write");
                end else begin
                    e = exp_wr.pop_front();
                    chk("write_address", DRAM_Address, e.addr);
                    chk("write_data", DRAM_WriteData, e.data);
                end
            end else if (DRAM_Write && prev_write) begin
                chk("hold_address", DRAM_Address, prev_addr);
                chk("hold_data", DRAM_WriteData, prev_data);
            end
            if (finished) begin
                fin_seen++;
                fin_cyc = cyc;
                chk("finished_single_pulse", 32'(prev_fin), 32'd0);
                if (exp_fin == 0) begin
                    fail_event("unexpected_finished");
                end else begin
                    exp_fin--;
                    chk("writes_pending_at_finish", exp_wr.size(), 0);
                end
            end
            rows = 0;
            ok   = 1'b1;
            for (int p = 0; p < PU_NUM; p++) begin
                if (OB_r_enable[p] == '1) rows++;
                else if (OB_r_enable[p] != '0) ok = 1'b0;
            end
            chk("ob_r_enable_shape", 32'(ok && rows <= 1), 32'd1);
        end
        en_seen    = OB_r_enable;
        prev_write = DRAM_Write;
        prev_fin   = finished;
        prev_addr  = DRAM_Address;
        prev_data  = DRAM_WriteData;
    end

    // ---------------- stimulus ----------------
    int s_cyc = 0;

    task automatic fill_random();
        int t;
        for (int p = 0; p < PU_NUM; p++) begin
            for (int c = 0; c < OUTPUT_CHANNEL; c++) begin
                t = int'($urandom_range(0, 1200)) - 600;
                ob_mem[p][c] = OUT_BIN_LEN'(t);
            end
        end
    endtask

    task automatic do_start(input logic [31:0] addr, input int orc, input bit extra);
        ORC_Size = ORC_W'(orc);
        output_start_address = addr;
        OC_Num = OC_W'($urandom);
        model_start(orc, addr);
        @(posedge clock);
        #1 start = 1'b1;
        s_cyc = cyc;
        @(posedge clock);
        #1 start = 1'b0;
        if (extra) begin
            repeat (4) @(posedge clock);
            #1 start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
        end
    endtask

    task automatic wait_finish(input int f0, output int lat);
        for (int i = 0; i < 2000 && fin_seen == f0; i++) @(posedge clock);
        if (fin_seen == f0) begin
            fail_event("finished_timeout");
            lat = -1;
        end else begin
            lat = fin_cyc - s_cyc + 1;
        end
        repeat (2) @(posedge clock);
    endtask

    task automatic run_tile(input logic [31:0] addr, input int orc, input bit extra, output int lat);
        int f0;
        f0 = fin_seen;
        do_start(addr, orc, extra);
        wait_finish(f0, lat);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    logic [31:0] tile_base[5];
    logic [31:0] word_a;
    int lat;
    int f0;

    initial begin
        tile_base[0] = 32'h2000;
        tile_base[1] = 32'h2010;
        tile_base[2] = 32'h2020;
        tile_base[3] = 32'h2030;
        tile_base[4] = 32'h6000;
        reset = 1'b1;
        start = 1'b0;
        OC_Num = '0;
        ORC_Size = '0;
        output_start_address = '0;
        DRAM_WriteDone = 1'b0;
        OB_rdata = '0;
        for (int p = 0; p < PU_NUM; p++)
            for (int c = 0; c < OUTPUT_CHANNEL; c++) ob_mem[p][c] = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_DRAM_Write", 32'(DRAM_Write), 32'd0);
        chk("reset_finished", 32'(finished), 32'd0);
        chk("reset_OB_r_enable", 32'(OB_r_enable), 32'd0);
        chk("reset_DRAM_Address", DRAM_Address, 32'd0);
        chk("reset_DRAM_WriteData", DRAM_WriteData, 32'd0);
        #1 reset = 1'b0;

        // Saturating lane packing, address sequence and minimum latency.
        fill_random();
        ob_mem[0][0] = 16'sd300;
        ob_mem[0][1] = -16'sd300;
        ob_mem[0][2] = 16'sd5;
        ob_mem[0][3] = -16'sd5;
        wr_addr_log.delete();
        wr_data_log.delete();
        run_tile(32'h1000, OUTPUT_WIDTH, 1'b0, lat);
        chk("min_latency", lat, 23);
        chk("write_count", wr_addr_log.size(), PU_NUM);
        for (int p = 0; p < PU_NUM && p < wr_addr_log.size(); p++)
            chk("seq_address", wr_addr_log[p], 32'h1000 + 32'(4 * p));
`ifdef DELTA_OUT_RELU_EN
        word_a = 32'h0005_007F;
`else
        word_a = 32'hFB05_807F;
`endif
        if (wr_data_log.size() > 0) chk("lanes_300_m300_5_m5", wr_data_log[0], word_a);

        // Slow acceptance with stray WriteDone pulses and an ignored mid-tile start.
        d_min = 7;
        d_max = 7;
        spur_en = 1'b1;
        fill_random();
        run_tile(32'h9000, OUTPUT_WIDTH, 1'b1, lat);
        chk("latency_delay7", lat, 47);

        // Tile walk with ORC_Size equal to the tile step; fifth start rebases.
        pulse_reset();
        d_min = 1;
        d_max = 3;
        for (int k = 0; k < 5; k++) begin
            fill_random();
            wr_addr_log.delete();
            run_tile(32'h2000 + 32'(k) * 32'h1000, OUTPUT_WIDTH, 1'b0, lat);
            if (wr_addr_log.size() == 0) fail_event("tile_walk_no_write");
            else chk("tile_walk_base", wr_addr_log[0], tile_base[k]);
        end

        // Reset in the middle of a write abandons it.
        d_min = 5;
        d_max = 5;
        spur_en = 1'b0;
        fill_random();
        f0 = fin_seen;
        do_start(32'h7000, OUTPUT_WIDTH, 1'b0);
        for (int i = 0; i < 100 && !DRAM_Write; i++) begin
            @(posedge clock);
            #1;
        end
        chk("write_before_reset", 32'(DRAM_Write), 32'd1);
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("reset_drops_write", 32'(DRAM_Write), 32'd0);
        chk("reset_clears_address", DRAM_Address, 32'd0);
        chk("reset_clears_data", DRAM_WriteData, 32'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        repeat (10) @(posedge clock);
        chk("no_finish_after_abort", fin_seen, f0);
        fill_random();
        wr_addr_log.delete();
        run_tile(32'h8000, OUTPUT_WIDTH, 1'b0, lat);
        if (wr_addr_log.size() == 0) fail_event("rewrite_no_write");
        else chk("rewrite_from_start_address", wr_addr_log[0], 32'h8000);

        // Random tiles.
        d_min = 1;
        d_max = 4;
        spur_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            fill_random();
            run_tile($urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), lat);
        end
        chk("scoreboard_drained", exp_wr.size(), 0);
        chk("finishes_drained", exp_fin, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
